// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module      : cpu_pkg
//  Description : Opcode constants and fetch-unit types shared by the core.
//                The HALT state exists only when FETCH_HALT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ALU   = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_STORE = 4'h3;
  localparam logic [3:0] OP_BEQ   = 4'h4;
  localparam logic [3:0] OP_BNE   = 4'h5;
  localparam logic [3:0] OP_BLT   = 4'h6;
  localparam logic [3:0] OP_JMP   = 4'h7;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
`ifdef FETCH_HALT_EN
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
`else
    ST_ISSUE = 2'd2
`endif
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_HOLD   = 2'd0,
    PC_INC    = 2'd1,
    PC_BRANCH = 2'd2
  } pc_sel_t;

endpackage

`default_nettype wire

// File: rtl/pc_next.sv
// ============================================================================
//  Module      : pc_next
//  Description : Combinational next-PC select: hold, increment (wrapping
//                modulo 2^ADDR_W) or branch target.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_next
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic [ADDR_W-1:0] i_pc,
  input  pc_sel_t           i_sel,
  input  logic [ADDR_W-1:0] i_branch_target,
  output logic [ADDR_W-1:0] o_pc_next
);

  always_comb begin
    o_pc_next = i_pc;
    case (i_sel)
      PC_INC:    o_pc_next = i_pc + ADDR_W'(1);
      PC_BRANCH: o_pc_next = i_branch_target;
      default:   o_pc_next = i_pc;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
//  Module      : instr_fetch
//  Description : Instruction fetch FSM (IDLE/REQ/ISSUE[/HALT]) with a
//                variable-latency memory handshake and branch redirect.
//                Define FETCH_HALT_EN to stop fetching after OP_HALT issues.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 10,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               ni,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [3:0]         op_code,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc_out
);

  fetch_state_t        r_state;
  fetch_state_t        w_state_nxt;
  pc_sel_t             w_pc_sel;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   w_pc_nxt;
  logic [INSTR_W-1:0]  r_instr;
  logic [ADDR_W-1:0]   r_pc_out;
  logic                w_accept;

  // Data is only taken while a request is outstanding; a late valid is dropped.
  assign w_accept = (r_state == ST_REQ) && imem_valid;

  pc_next #(
    .ADDR_W (ADDR_W)
  ) u_pc_next (
    .i_pc            (r_pc),
    .i_sel           (w_pc_sel),
    .i_branch_target (branch_target),
    .o_pc_next       (w_pc_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_pc     <= RESET_PC;
      r_instr  <= '0;
      r_pc_out <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_accept) begin
        r_instr  <= imem_rdata;
        r_pc_out <= r_pc;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_sel    = PC_HOLD;
    case (r_state)
      ST_IDLE: w_state_nxt = ST_REQ;
      ST_REQ: begin
        if (imem_valid) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (!stall) begin
`ifdef FETCH_HALT_EN
          if (op_code == OP_HALT) begin
            w_state_nxt = ST_HALT;
          end else begin
            w_state_nxt = ST_REQ;
            w_pc_sel    = ni ? PC_BRANCH : PC_INC;
          end
`else
          w_state_nxt = ST_REQ;
          w_pc_sel    = ni ? PC_BRANCH : PC_INC;
`endif
        end
      end
`ifdef FETCH_HALT_EN
      ST_HALT: w_state_nxt = ST_HALT;
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign imem_req    = (r_state == ST_REQ);
  assign imem_addr   = r_pc;
  assign instr_valid = (r_state == ST_ISSUE);
  assign instr       = r_instr;
  assign op_code     = r_instr[INSTR_W-1 -: 4];
  assign pc_out      = r_pc_out;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
//  Module      : tb_instr_fetch
//  Description : Scoreboard bench for instr_fetch with a variable-latency
//                memory responder; a second ADDR_W=4 instance covers wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch;

  localparam int AW = 10;
  localparam int IW = 32;

  logic          clk;
  logic          rst;
  logic          stall;
  logic          ni;
  logic [AW-1:0] branch_target;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata;
  logic          imem_valid;
  logic [IW-1:0] instr;
  logic [3:0]    op_code;
  logic          instr_valid;
  logic [AW-1:0] pc_out;

  logic          rst4;
  logic          stall4;
  logic          ni4;
  logic [3:0]    bt4;
  logic          req4;
  logic [3:0]    addr4;
  logic [IW-1:0] rdata4;
  logic          valid4;
  logic [IW-1:0] instr4;
  logic [3:0]    op4;
  logic          iv4;
  logic [3:0]    pc_out4;

  int            checks;
  int            errors;

  logic [IW-1:0] mem [0:(1<<AW)-1];
  logic          mem_en;
  int            mem_wait;
  logic          force_valid;
  logic [IW-1:0] force_data;
  logic [AW-1:0] q_addr [$];
  logic [IW-1:0] q_data [$];

  instr_fetch #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC('0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .ni(ni), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_valid(imem_valid), .instr(instr), .op_code(op_code),
    .instr_valid(instr_valid), .pc_out(pc_out)
  );

  instr_fetch #(.ADDR_W(4), .INSTR_W(IW), .RESET_PC(4'd15)) dut4 (
    .clk(clk), .rst(rst4), .stall(stall4), .ni(ni4), .branch_target(bt4),
    .imem_req(req4), .imem_addr(addr4), .imem_rdata(rdata4),
    .imem_valid(valid4), .instr(instr4), .op_code(op4),
    .instr_valid(iv4), .pc_out(pc_out4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory responder: answers after mem_wait wait states, records expectations.
  initial begin
    int wcnt;
    wcnt = 0;
    for (int i = 0; i < (1 << AW); i++)
      mem[i] = {4'((i % 14) + 1), 28'(i * 32'h9E37)};
    mem[64] = 32'hF000_0000;
    imem_valid = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_en && imem_req && !rst) begin
        if (wcnt == mem_wait) begin
          imem_valid = 1'b1;
          imem_rdata = mem[imem_addr];
          q_addr.push_back(imem_addr);
          q_data.push_back(mem[imem_addr]);
          wcnt = 0;
        end else begin
          imem_valid = 1'b0;
          imem_rdata = 32'hBAD0_0BAD;
          wcnt++;
        end
      end else begin
        imem_valid = force_valid;
        imem_rdata = force_data;
        wcnt = 0;
      end
    end
  end

  // Issue monitor: every new ISSUE must match the oldest accepted fetch.
  initial begin
    logic          prev_v;
    logic [AW-1:0] ea;
    logic [IW-1:0] ed;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (instr_valid && !prev_v) begin
        checks++;
        if (q_addr.size() == 0) begin
          errors++;
          $display("FAIL issue_unexpected instr=%h pc_out=%h, no fetch outstanding", instr, pc_out);
        end else begin
          ea = q_addr.pop_front();
          ed = q_data.pop_front();
          if (instr !== ed || pc_out !== ea || op_code !== ed[IW-1 -: 4]) begin
            errors++;
            $display("FAIL issue_data instr=%h pc_out=%h op=%h, expected instr=%h pc_out=%h op=%h",
                     instr, pc_out, op_code, ed, ea, ed[IW-1 -: 4]);
          end
        end
      end
      prev_v = instr_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_issue();
    for (int i = 0; i < 30 && !instr_valid; i++) tick();
    checks++;
    if (instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL issue_timeout instr_valid=%b, expected 1 within 30 cycles", instr_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b1; ni = 1'b1; mem_wait = 0;
    tick(); tick();
    rst = 1'b0; stall = 1'b0; ni = 1'b0;
    checks++;
    if ({imem_req, instr_valid, instr, op_code, pc_out} !== {1'b0, 1'b0, 32'h0, 4'h0, 10'h0}) begin
      errors++;
      $display("FAIL reset_state req=%b valid=%b instr=%h op=%h pc_out=%h, expected all zero",
               imem_req, instr_valid, instr, op_code, pc_out);
    end
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 10'h0) begin
      errors++;
      $display("FAIL first_req req=%b addr=%h, expected req=1 addr=0", imem_req, imem_addr);
    end
    tick();
    checks++;
    if (instr_valid !== 1'b1 || op_code !== 4'h1 || pc_out !== 10'h0) begin
      errors++;
      $display("FAIL zero_wait valid=%b op=%h pc_out=%h, expected valid=1 op=1 pc_out=0",
               instr_valid, op_code, pc_out);
    end
  endtask

  task automatic test_wait();
    int n;
    logic stable;
    n = 0; stable = 1'b1;
    mem_wait = 3;
    tick();
    for (int i = 0; i < 12 && !instr_valid; i++) begin
      if (imem_req) begin
        n++;
        if (imem_addr !== 10'h1) stable = 1'b0;
      end
      tick();
    end
    mem_wait = 0;
    checks++;
    if (n != 4 || !stable) begin
      errors++;
      $display("FAIL wait_states req_cycles=%0d stable=%b, expected 4 (3 wait + accept) stable=1", n, stable);
    end
    checks++;
    if (instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL wait_capture valid=%b, expected 1", instr_valid);
    end
  endtask

  task automatic test_stall_branch();
    ni = 1'b1; branch_target = 10'h5;
    tick();
    ni = 1'b0;
    wait_issue();
    checks++;
    if (pc_out !== 10'h5) begin
      errors++;
      $display("FAIL branch_to_5 pc_out=%h, expected 005", pc_out);
    end
    stall = 1'b1; ni = 1'b1; branch_target = 10'h20;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({instr_valid, imem_req, pc_out} !== {1'b1, 1'b0, 10'h5}) begin
        errors++;
        $display("FAIL stall_hold valid=%b req=%b pc_out=%h, expected 1 0 005", instr_valid, imem_req, pc_out);
      end
    end
    stall = 1'b0; mem_wait = 2;
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 10'h20) begin
      errors++;
      $display("FAIL redirect req=%b addr=%h, expected 1 020", imem_req, imem_addr);
    end
    ni = 1'b1; branch_target = 10'h3FF;
    tick();
    branch_target = 10'h155; ni = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 10'h20) begin
      errors++;
      $display("FAIL req_ignores_ni req=%b addr=%h, expected 1 020", imem_req, imem_addr);
    end
    ni = 1'b1;
    wait_issue();
    ni = 1'b0; mem_wait = 0;
    checks++;
    if (pc_out !== 10'h20) begin
      errors++;
      $display("FAIL req_ignores_target pc_out=%h, expected 020", pc_out);
    end
    tick();
    checks++;
    if (imem_addr !== 10'h21) begin
      errors++;
      $display("FAIL increment addr=%h, expected 021", imem_addr);
    end
  endtask

  task automatic test_wrap();
    wait_issue();
    ni = 1'b1; branch_target = 10'h3FF;
    tick();
    ni = 1'b0;
    wait_issue();
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 10'h0) begin
      errors++;
      $display("FAIL wrap10 req=%b addr=%h, expected 1 000", imem_req, imem_addr);
    end
  endtask

  task automatic test_wrap4();
    rst4 = 1'b1;
    tick();
    rst4 = 1'b0;
    tick();
    checks++;
    if (req4 !== 1'b1 || addr4 !== 4'hF) begin
      errors++;
      $display("FAIL reset_pc4 req=%b addr=%h, expected 1 f", req4, addr4);
    end
    tick();
    checks++;
    if (iv4 !== 1'b1 || pc_out4 !== 4'hF || op4 !== 4'h2) begin
      errors++;
      $display("FAIL issue4 valid=%b pc_out=%h op=%h, expected 1 f 2", iv4, pc_out4, op4);
    end
    tick();
    checks++;
    if (req4 !== 1'b1 || addr4 !== 4'h0) begin
      errors++;
      $display("FAIL wrap4 req=%b addr=%h, expected 1 0", req4, addr4);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    n = 0;
    mem_wait = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (instr_valid) n++;
    end
    checks++;
    if (n != 10) begin
      errors++;
      $display("FAIL throughput issues=%0d in 20 cycles, expected 10", n);
    end
  endtask

  task automatic test_reset_mid_req();
    wait_issue();
    mem_wait = 10;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; mem_en = 1'b0; force_valid = 1'b1; force_data = 32'hDEAD_BEEF;
    checks++;
    if (imem_req !== 1'b0 || instr !== 32'h0) begin
      errors++;
      $display("FAIL reset_abort req=%b instr=%h, expected 0 00000000", imem_req, instr);
    end
    tick();
    force_valid = 1'b0; mem_en = 1'b1; mem_wait = 0;
    checks++;
    if ({instr, instr_valid, imem_req, imem_addr} !== {32'h0, 1'b0, 1'b1, 10'h0}) begin
      errors++;
      $display("FAIL late_valid instr=%h valid=%b req=%b addr=%h, expected 00000000 0 1 000",
               instr, instr_valid, imem_req, imem_addr);
    end
    wait_issue();
    checks++;
    if (instr !== 32'h1000_0000 || pc_out !== 10'h0) begin
      errors++;
      $display("FAIL refetch instr=%h pc_out=%h, expected 10000000 000", instr, pc_out);
    end
  endtask

  task automatic test_halt();
    ni = 1'b1; branch_target = 10'd64;
    tick();
    ni = 1'b0;
    wait_issue();
    checks++;
    if (op_code !== 4'hF) begin
      errors++;
      $display("FAIL halt_op op=%h, expected f", op_code);
    end
    tick();
`ifdef FETCH_HALT_EN
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
        if (imem_req || instr_valid || imem_addr !== 10'd64) bad++;
        tick();
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL halt_hold bad_cycles=%0d, expected 0", bad);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 10'h0) begin
        errors++;
        $display("FAIL halt_exit req=%b addr=%h, expected 1 000", imem_req, imem_addr);
      end
    end
`else
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 10'd65) begin
      errors++;
      $display("FAIL halt_disabled req=%b addr=%h, expected 1 041", imem_req, imem_addr);
    end
`endif
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; stall = 1'b0; ni = 1'b0; branch_target = '0;
    mem_en = 1'b1; mem_wait = 0; force_valid = 1'b0; force_data = '0;
    rst4 = 1'b1; stall4 = 1'b0; ni4 = 1'b0; bt4 = '0;
    valid4 = 1'b1; rdata4 = 32'h2000_0000;
    test_reset();
    test_wait();
    test_stall_branch();
    test_wrap();
    test_wrap4();
    test_back_to_back();
    test_reset_mid_req();
    test_halt();
    repeat (4) tick();
    checks++;
    if (q_addr.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending=%0d, expected 0", q_addr.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
